// File: rtl/example_mul_mac_pipe.sv
// Signed x unsigned multiply / multiply-accumulate with NUM_STAGE-deep register pipeline and saturating output.
// One shared enable advances every stage; the whole pipe stalls while a result waits on out_rdy.
module example_mul_mac_pipe #(
    parameter int ID         = 1,
    parameter int NUM_STAGE  = 3,
    parameter int DIN0_WIDTH = 14,
    parameter int DIN1_WIDTH = 6,
    parameter int DOUT_WIDTH = 20
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  in_vld,
    output logic                  in_rdy,
    input  logic [DIN0_WIDTH-1:0] din0,
    input  logic [DIN1_WIDTH-1:0] din1,
    input  logic                  mode,
    input  logic                  last,
    output logic                  out_vld,
    input  logic                  out_rdy,
    output logic [DOUT_WIDTH-1:0] dout,
    output logic                  ovf
);

    localparam int PW = DIN0_WIDTH + DIN1_WIDTH;
    localparam int SW = ((PW > DOUT_WIDTH) ? PW : DOUT_WIDTH) + 1;

    generate
        if (NUM_STAGE < 1 || DOUT_WIDTH < 2 || ID < 0) begin : g_bad_param
            $error("example_mul_mac_pipe: illegal parameter value");
        end
    endgenerate

    logic ce;
    logic take;

    assign ce     = ~out_vld | out_rdy;
    assign in_rdy = ap_rst_n & ce;
    assign take   = in_vld & in_rdy;

    // PW bits hold the exact product because din1 is non-negative.
    function automatic logic [PW-1:0] mul(input logic [DIN0_WIDTH-1:0] a,
                                          input logic [DIN1_WIDTH-1:0] b);
        logic signed [PW-1:0] ax;
        logic signed [PW-1:0] bx;
        ax = {{DIN1_WIDTH{a[DIN0_WIDTH-1]}}, a};
        bx = {{DIN0_WIDTH{1'b0}}, b};
        return ax * bx;
    endfunction

    logic          fin_vld;
    logic          fin_mode;
    logic          fin_last;
    logic [PW-1:0] fin_p;

    generate
        if (NUM_STAGE == 1) begin : g_comb
            assign fin_vld  = take;
            assign fin_mode = mode;
            assign fin_last = last;
            assign fin_p    = mul(din0, din1);
        end else begin : g_reg
            logic                  op_vld;
            logic                  op_mode;
            logic                  op_last;
            logic [DIN0_WIDTH-1:0] op_a;
            logic [DIN1_WIDTH-1:0] op_b;

            always_ff @(posedge ap_clk or negedge ap_rst_n) begin
                if (!ap_rst_n) begin
                    op_vld  <= 1'b0;
                    op_mode <= 1'b0;
                    op_last <= 1'b0;
                    op_a    <= '0;
                    op_b    <= '0;
                end else if (ce) begin
                    op_vld  <= take;
                    op_mode <= mode;
                    op_last <= last;
                    op_a    <= din0;
                    op_b    <= din1;
                end
            end

            if (NUM_STAGE == 2) begin : g_direct
                assign fin_vld  = op_vld;
                assign fin_mode = op_mode;
                assign fin_last = op_last;
                assign fin_p    = mul(op_a, op_b);
            end else begin : g_prod
                localparam int ND = NUM_STAGE - 2;

                logic [ND-1:0] pv;
                logic [ND-1:0] pm;
                logic [ND-1:0] pl;
                logic [PW-1:0] pp [ND];

                always_ff @(posedge ap_clk or negedge ap_rst_n) begin
                    if (!ap_rst_n) begin
                        pv <= '0;
                        pm <= '0;
                        pl <= '0;
                        for (int i = 0; i < ND; i++) pp[i] <= '0;
                    end else if (ce) begin
                        pv[0] <= op_vld;
                        pm[0] <= op_mode;
                        pl[0] <= op_last;
                        pp[0] <= mul(op_a, op_b);
                        for (int i = 1; i < ND; i++) begin
                            pv[i] <= pv[i-1];
                            pm[i] <= pm[i-1];
                            pl[i] <= pl[i-1];
                            pp[i] <= pp[i-1];
                        end
                    end
                end

                assign fin_vld  = pv[ND-1];
                assign fin_mode = pm[ND-1];
                assign fin_last = pl[ND-1];
                assign fin_p    = pp[ND-1];
            end
        end
    endgenerate

    logic [DOUT_WIDTH-1:0] acc;
    logic signed [SW-1:0]  p_ext;
    logic signed [SW-1:0]  acc_ext;
    logic signed [SW-1:0]  sel;
    logic                  sel_ovf;
    logic [DOUT_WIDTH-1:0] sel_sat;

    // The sum is one bit wider than either operand, so only the clamp can lose range.
    always_comb begin
        p_ext   = {{(SW-PW){fin_p[PW-1]}}, fin_p};
        acc_ext = {{(SW-DOUT_WIDTH){acc[DOUT_WIDTH-1]}}, acc};
        sel     = fin_mode ? (acc_ext + p_ext) : p_ext;
        sel_ovf = ~((&sel[SW-1:DOUT_WIDTH-1]) | ~(|sel[SW-1:DOUT_WIDTH-1]));
        sel_sat = sel_ovf ? {sel[SW-1], {(DOUT_WIDTH-1){~sel[SW-1]}}}
                          : sel[DOUT_WIDTH-1:0];
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            out_vld <= 1'b0;
            dout    <= '0;
            acc     <= '0;
            ovf     <= 1'b0;
        end else if (ce) begin
            if (fin_vld) begin
                if (sel_ovf) ovf <= 1'b1;
                if (!fin_mode) begin
                    dout    <= sel_sat;
                    out_vld <= 1'b1;
                end else if (fin_last) begin
                    dout    <= sel_sat;
                    out_vld <= 1'b1;
                    acc     <= '0;
                end else begin
                    acc     <= sel_sat;
                    out_vld <= 1'b0;
                end
            end else begin
                out_vld <= 1'b0;
            end
        end
    end

endmodule

// File: doc/example_mul_mac_pipe.md
Name: example_mul_mac_pipe

Overview:
Pipelined, parametrised successor to the combinational signed×unsigned HLS multiplier. Computes din0 (signed) × din1 (unsigned, zero-extended) through a configurable register pipeline. Adds valid/ready flow control, per-beat multiply or accumulate mode, and saturating output. Sits in the datapath wherever a backpressure-tolerant multiply or MAC is required.

Parameters:
ID, 1, instance tag; no functional effect
NUM_STAGE, 3, pipeline depth in cycles, legal values ≥1
DIN0_WIDTH, 14, signed operand width
DIN1_WIDTH, 6, unsigned operand width
DOUT_WIDTH, 20, output and accumulator width, legal values ≥2

Ports:
ap_clk  in  1  clock, rising edge
ap_rst_n  in  1  asynchronous active-low reset
in_vld  in  1  input beat valid
in_rdy  out  1  block can accept a beat
din0  in  DIN0_WIDTH  signed operand
din1  in  DIN1_WIDTH  unsigned operand
mode  in  1  0 = multiply, 1 = accumulate
last  in  1  accumulate mode only: closes the sum; ignored when mode = 0
out_vld  out  1  result valid
out_rdy  in  1  downstream accepts the result
dout  out  DOUT_WIDTH  saturated signed result
ovf  out  1  sticky flag, set if any emitted result saturated

Behaviour:
- Reset: ap_rst_n low asynchronously clears all stage valids, out_vld, dout, the accumulator and ovf to 0. in_rdy is 0 while reset is asserted. A reset mid-operation discards all in-flight beats and any partial sum.
- Product: P = $signed(din0) × $signed({1'b0, din1}). P is exact at DIN0_WIDTH+DIN1_WIDTH bits and is sign-extended before any sum.
- Sum width: the internal sum is computed one bit wider than max(P width, DOUT_WIDTH) so it cannot overflow. Saturation to the DOUT_WIDTH signed range happens only at the final stage.
- Pipeline: a single enable, ce = !out_vld | out_rdy, advances all stages together. A beat is accepted when in_vld & in_rdy, with in_rdy = ce. Bubbles travel as valid = 0 and are not collapsed.
- Latency: a beat accepted on edge t produces its output at edge t+NUM_STAGE, assuming no stall.
  - NUM_STAGE = 1: the product is combinational into the final register.
  - NUM_STAGE ≥ 2: the operands are registered first and the product is registered through the remaining stages.
- mode and last travel down the pipeline with their beat.
- Final stage, on ce with a valid beat:
  - mode = 0: dout ← sat(P), out_vld ← 1. The accumulator is untouched.
  - mode = 1, last = 0: acc ← sat(acc + P), out_vld ← 0. No result is emitted.
  - mode = 1, last = 1: dout ← sat(acc + P), out_vld ← 1, acc ← 0.
- Final stage, on ce with no valid beat: out_vld ← 0.
- Accumulator saturation: acc saturates at every update, so a sum that once saturates stays clamped until it recovers arithmetically.
- Interleaving: mode = 0 beats may be interleaved inside an accumulate sequence without disturbing acc.
- ovf: set on any emitted or accumulated saturation. It is cleared only by reset.
- Stall: while out_vld & !out_rdy, dout, out_vld and all stages hold, and in_rdy = 0. Single-cycle handoff is required: when out_rdy = 1, one beat per cycle is sustained.
- sat(x): clamps to [-2^(DOUT_WIDTH-1), 2^(DOUT_WIDTH-1)-1]. No rounding is applied.

Test Plan:
- Multiply path (defaults): mode 0, din0 = 100, din1 = 5, accepted at edge 0 → out_vld at edge 3, dout = 500, ovf = 0. Also din0 = -8192, din1 = 63 → dout = -516096.
- Accumulate sequence: (3,4), (-2,5), (7,1, last = 1), all mode 1, back-to-back → exactly one output, dout = 9. The next sequence (1,1, last) → dout = 1, confirming acc was cleared.
- Saturation: mode 1, (-8192,63), then (-8192,63, last) → dout = -524288 and ovf = 1. Also mode 0 with DOUT_WIDTH = 16 and (-8192,63) → dout = -32768.
- Backpressure: stream 6 mode-0 beats with out_rdy = 0 for edges 3–7 → in_rdy = 0 during the stall, dout holds the first result, and all 6 results emerge in order with none lost or duplicated.
- Reset mid-operation: send two accumulate beats, pulse ap_rst_n low for half a cycle (asynchronously) → out_vld = 0 and dout = 0 immediately. A subsequent (2,3, last) → dout = 6.
- NUM_STAGE = 1: mode 0 beat (5,5) → dout = 25 on the next edge. Alternate in_vld each cycle → output valids mirror the gaps with latency 1.
